// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned MUL/MULH/DIV/REM sharing the ALU data/addr/result buses.
// Latency: WIDTH cycles from the start edge to the done pulse. busy is high for all of them.
// Backpressure: none. A start while busy is dropped, and the control unit stalls on busy.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             oe,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output tri   [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output logic [3:0]       status
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam logic [1:0] OP_MUL  = 2'd0;
   localparam logic [1:0] OP_MULH = 2'd1;
   localparam logic [1:0] OP_DIV  = 2'd2;

   state_t             state, state_nx;
   logic [1:0]         op_q;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;     // {partial product, remaining multiplier bits}
   logic [WIDTH-1:0]   k;       // multiplicand for MUL/MULH, divisor for DIV/REM
   logic [WIDTH-1:0]   quo;     // dividend bits shift out of the top as quotient bits shift in
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   result;
   logic [3:0]         status_q;

   logic               accept, last;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_nx;
   logic [WIDTH:0]     rem_sh, diff;
   logic               div_zero, ge;
   logic [WIDTH-1:0]   rem_nx, quo_nx, res;
   logic               v_flag;

   assign out = oe ? result : {WIDTH{1'bz}};
   assign status = status_q;

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      case (state)
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = FINISH;
         end
         FINISH: begin
            done = 1'b1;
            accept = start;
            state_nx = start ? RUN : IDLE;
         end
         default: begin
            accept = start;
            if (start) state_nx = RUN;
         end
      endcase
   end

   assign last = (cnt == CNT_W'(1));

   // The borrow of the WIDTH+1 bit subtract is the compare result. A zero
   // divisor forces every quotient bit to 1, leaving the dividend as remainder.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, k} : {(WIDTH+1){1'b0}});
      acc_nx   = {sum, acc[WIDTH-1:1]};
      div_zero = (k == '0);
      rem_sh   = {rem, quo[WIDTH-1]};
      diff     = rem_sh - {1'b0, k};
      ge       = ~diff[WIDTH] | div_zero;
      rem_nx   = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_nx   = {quo[WIDTH-2:0], ge};
      case (op_q)
         OP_MUL:  begin res = acc_nx[WIDTH-1:0];       v_flag = |acc_nx[2*WIDTH-1:WIDTH]; end
         OP_MULH: begin res = acc_nx[2*WIDTH-1:WIDTH]; v_flag = 1'b0;                     end
         OP_DIV:  begin res = quo_nx;                  v_flag = div_zero;                 end
         default: begin res = rem_nx;                  v_flag = div_zero;                 end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= 2'd0;
         cnt      <= '0;
         acc      <= '0;
         k        <= '0;
         quo      <= '0;
         rem      <= '0;
         result   <= '0;
         status_q <= 4'b0100;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q <= op;
            cnt  <= CNT_W'(WIDTH);
            acc  <= {{WIDTH{1'b0}}, b};
            k    <= op[1] ? b : a;
            quo  <= a;
            rem  <= '0;
         end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_nx;
            quo <= quo_nx;
            rem <= rem_nx;
            if (last) begin
               result   <= res;
               status_q <= {res[WIDTH-1], (res == '0), 1'b0, v_flag};
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, busy/reset sequences, and random ops against an arithmetic model.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, oe;
   logic [1:0]  op;
   logic [31:0] a, b;
   tri1  [31:0] out_w;
   logic        busy, done;
   logic [3:0]  status;

   int tests = 0;
   int fails = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .oe(oe),
      .a(a), .b(b), .out(out_w), .busy(busy), .done(done), .status(status)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  st;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain-arithmetic reference: full 64-bit product, native divide and modulo.
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] s);
      logic [63:0] p;
      logic        v;
      p = {32'd0, x} * {32'd0, y};
      case (o)
         2'd0: begin r = p[31:0];  v = (p[63:32] != 0); end
         2'd1: begin r = p[63:32]; v = 1'b0; end
         2'd2: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; v = (y == 0); end
         default: begin r = (y == 0) ? x : x % y; v = (y == 0); end
      endcase
      s = {r[31], (r == 0), 1'b0, v};
   endfunction

   // Issues one op and waits for done. If poke >= 0, a stray start is driven
   // in that cycle of the run, which the unit must ignore.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int poke, output logic [31:0] r, output logic [3:0] s,
                         output int lat, output logic ok);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom;
      ok = (busy === 1'b1) && (done === 1'b0);
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (lat == poke) begin
            start = 1'b1; op = 2'd2; a = 32'd1; b = 32'd1;
         end else begin
            start = 1'b0;
         end
         tick();
         lat++;
         if (done !== 1'b1 && busy !== 1'b1) ok = 1'b0;
      end
      start = 1'b0;
      if (busy !== 1'b0) ok = 1'b0;
      r = out_w;
      s = status;
   endtask

   initial begin
      logic [31:0] r, er;
      logic [3:0]  s, es;
      int          lat;
      logic        ok;
      int          seen;

      rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; oe = 1'b0;
      tick();
      tick();
      chk("reset_hiz", out_w, 32'hFFFF_FFFF);
      rst = 1'b0;
      oe = 1'b1;
      #1;
      chk("reset_out", out_w, 32'h0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_status", {28'd0, status}, 32'h4);
      tick();

      vt[0]  = '{2'd0, 32'd7,          32'd6,          32'h0000_002A, 4'b0000};
      vt[1]  = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 4'b0001};
      vt[2]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 4'b1000};
      vt[3]  = '{2'd2, 32'd100,        32'd7,          32'd14,        4'b0000};
      vt[4]  = '{2'd3, 32'd100,        32'd7,          32'd2,         4'b0000};
      vt[5]  = '{2'd2, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 4'b1001};
      vt[6]  = '{2'd3, 32'h1234_5678,  32'd0,          32'h1234_5678, 4'b0001};
      vt[7]  = '{2'd0, 32'd0,          32'd5,          32'h0,         4'b0100};
      vt[8]  = '{2'd1, 32'h0001_0000,  32'h0001_0000,  32'h1,         4'b0000};
      vt[9]  = '{2'd0, 32'h0001_0000,  32'h0001_0000,  32'h0,         4'b0101};
      vt[10] = '{2'd2, 32'd5,          32'd9,          32'h0,         4'b0100};
      vt[11] = '{2'd3, 32'd5,          32'd9,          32'd5,         4'b0000};
      vt[12] = '{2'd2, 32'h8000_0000,  32'd1,          32'h8000_0000, 4'b1000};

      // Consecutive calls start in the done cycle, so these are back-to-back.
      for (int i = 0; i < 13; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, -1, r, s, lat, ok);
         chk($sformatf("vec%0d_latency", i), lat, 32'd32);
         chk($sformatf("vec%0d_out", i), r, vt[i].res);
         chk($sformatf("vec%0d_status", i), {28'd0, s}, {28'd0, vt[i].st});
         chk($sformatf("vec%0d_busy", i), {31'd0, ok}, 32'd1);
      end
      tick();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("result_held", out_w, 32'h8000_0000);
      chk("status_held", {28'd0, status}, 32'h8);

      repeat (3) tick();
      run_op(2'd0, 32'd7, 32'd6, 10, r, s, lat, ok);
      chk("busy_start_latency", lat, 32'd32);
      chk("busy_start_out", r, 32'h2A);
      chk("busy_start_status", {28'd0, s}, 32'h0);
      chk("busy_start_busy", {31'd0, ok}, 32'd1);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            tick();
            oe = 1'b0;
            #1;
            chk($sformatf("rnd%0d_hiz", i), out_w, 32'hFFFF_FFFF);
            oe = 1'b1;
            #1;
         end
         model(ro, ra, rb, er, es);
         run_op(ro, ra, rb, -1, r, s, lat, ok);
         chk($sformatf("rnd%0d_latency", i), lat, 32'd32);
         chk($sformatf("rnd%0d_out", i), r, er);
         chk($sformatf("rnd%0d_status", i), {28'd0, s}, {28'd0, es});
      end

      tick();
      op = 2'd0; a = 32'd7; b = 32'd6; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_status", {28'd0, status}, 32'h4);
      chk("midrst_out", out_w, 32'h0);
      oe = 1'b0;
      #1;
      chk("midrst_hiz", out_w, 32'hFFFF_FFFF);
      oe = 1'b1;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("midrst_no_done", seen, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
